// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: byte FIFO on block RAM, drained one word at a time into a UART transmitter.
module uart_fifo_bridge #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  pause,
  input  logic                  flush,
  input  logic                  clr_ovf,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, READ, LOAD, WAIT_BUSY, WAIT_IDLE} state_t;
  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [ADDR_WIDTH-1:0]   wptr, rptr;
  logic [1:0]              guard;
  logic                    wr, pop;
  assign empty       = count == '0;
  assign full        = count == (ADDR_WIDTH+1)'(DEPTH);
  assign almost_full = count >= (ADDR_WIDTH+1)'(AFULL_LEVEL);
  assign wr          = rx_valid && !full && !flush;
  assign pop         = state == READ && !flush;
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= rx_data;
    if (state == READ) rd_q <= mem[rptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      guard    <= '0;
    end else begin
      wptr     <= flush ? '0 : wptr + ADDR_WIDTH'(wr);
      rptr     <= flush ? '0 : rptr + ADDR_WIDTH'(pop);
      count    <= flush ? '0 : count + (ADDR_WIDTH+1)'(wr) - (ADDR_WIDTH+1)'(pop);
      overflow <= (rx_valid && full && !flush) || (overflow && !clr_ovf);
      tx_start <= 1'b0;
      case (state)
        IDLE:      if (!empty && !pause && !tx_busy && !flush) state <= READ;
        READ:      state <= flush ? IDLE : LOAD;
        LOAD: begin
          tx_data  <= rd_q;
          tx_start <= 1'b1;
          guard    <= '0;
          state    <= WAIT_BUSY;
        end
        // a busy that never shows up must not hang the drain
        WAIT_BUSY: begin
          guard <= guard + 2'd1;
          if (tx_busy || guard == 2'd2) state <= WAIT_IDLE;
        end
        WAIT_IDLE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: randomized bench with a UART model and a queue scoreboard of words to transmit.
module tb_uart_fifo_bridge;
  localparam int DW = 8, AW = 4, DEPTH = 16;
  logic clk = 0, rst = 1, rx_valid = 0, tx_busy = 0, pause = 0, flush = 0, clr_ovf = 0;
  logic [DW-1:0] rx_data = '0;
  logic tx_start, empty, full, almost_full, overflow;
  logic [DW-1:0] tx_data;
  logic [AW:0] count;
  int n_chk = 0, n_fail = 0, starts = 0, busy_cnt = 0, busy_len = 3;
  bit rand_busy = 0, prev_start = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] head;

  uart_fifo_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(DEPTH - 2)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .pause(pause), .flush(flush), .clr_ovf(clr_ovf),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmitter model: every start pulse consumes the oldest expected word
  always @(negedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      tx_busy = busy_cnt != 0;
    end
    if (tx_start) begin
      starts++;
      chk("start_width", prev_start, 0);
      if (exp_q.size() == 0) chk("spurious_start", 1, 0);
      else begin
        head = exp_q.pop_front();
        chk("tx_data", tx_data, head);
      end
      busy_cnt = rand_busy ? int'($urandom_range(1, 6)) : busy_len;
      tx_busy = busy_cnt != 0;
    end
    prev_start = tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [DW-1:0] d);
    rx_valid = 1;
    rx_data = d;
    tick();
    rx_valid = 0;
  endtask

  task automatic push_write(input logic [DW-1:0] d);
    exp_q.push_back(d);
    write(d);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < limit) begin
      tick();
      n++;
    end
    chk("drain_done", n < limit, 1);
    repeat (8) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, n, sent_n;
    repeat (3) tick();
    check_reset("reset");
    rst = 0;
    tick();
    // single word latency
    exp_q.push_back(8'h41);
    write(8'h41);
    chk("count_after_write", count, 1);
    chk("start_e0", tx_start, 0);
    tick();
    chk("start_e1", tx_start, 0);
    tick();
    chk("start_e2", tx_start, 0);
    tick();
    chk("start_e3", tx_start, 1);
    chk("data_e3", tx_data, 8'h41);
    wait_drain(100);
    chk("single_count", count, 0);
    chk("single_empty", empty, 1);
    chk("single_starts", starts, 1);
    // fill while paused, overflow, drain in order
    pause = 1;
    busy_len = 4;
    for (int i = 0; i < DEPTH; i++) begin
      push_write(DW'(i));
      chk("fill_afull", almost_full, (i + 1) >= DEPTH - 2);
      chk("fill_full", full, i == DEPTH - 1);
    end
    chk("fill_count", count, DEPTH);
    write(8'h99);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, DEPTH);
    rx_valid = 1;
    clr_ovf = 1;
    tick();
    rx_valid = 0;
    clr_ovf = 0;
    chk("ovf_set_wins", overflow, 1);
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("ovf_clear", overflow, 0);
    s0 = starts;
    rand_busy = 1;
    pause = 0;
    wait_drain(2000);
    chk("fill_sent", starts - s0, DEPTH);
    chk("fill_drained_count", count, 0);
    chk("fill_drained_empty", empty, 1);
    // pop and write on the same edge at count 5
    pause = 1;
    for (int i = 0; i < 5; i++) push_write(DW'(8'hA0 + i));
    chk("five_count", count, 5);
    s0 = starts;
    pause = 0;
    tick();
    pause = 1;
    push_write(8'hB5);
    chk("same_cycle_count", count, 5);
    pause = 0;
    wait_drain(1000);
    chk("same_cycle_sent", starts - s0, 6);
    // 40-word random stream wraps the pointers
    s0 = starts;
    sent_n = 0;
    n = 0;
    while (sent_n < 40 && n < 5000) begin
      if (exp_q.size() < DEPTH - 1 && $urandom_range(0, 1) == 1) begin
        push_write(DW'($urandom));
        sent_n++;
      end else tick();
      n++;
    end
    chk("stream_written", sent_n, 40);
    wait_drain(2000);
    chk("stream_sent", starts - s0, 40);
    chk("stream_overflow", overflow, 0);
    chk("stream_count", count, 0);
    // busy never asserted: guard timeout keeps draining
    rand_busy = 0;
    busy_len = 0;
    s0 = starts;
    push_write(8'h11);
    push_write(8'h22);
    wait_drain(200);
    chk("nobusy_sent", starts - s0, 2);
    // flush during READ of the first word
    busy_len = 3;
    pause = 1;
    for (int i = 0; i < 8; i++) push_write(DW'(8'hC0 + i));
    chk("flush_pre_count", count, 8);
    s0 = starts;
    pause = 0;
    tick();
    flush = 1;
    rx_valid = 1;
    rx_data = 8'h77;
    tick();
    flush = 0;
    rx_valid = 0;
    exp_q.delete();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_overflow", overflow, 0);
    repeat (8) tick();
    chk("flush_no_start", starts, s0);
    push_write(8'h55);
    wait_drain(100);
    chk("post_flush_sent", starts - s0, 1);
    // reset while waiting for the UART to go idle
    busy_len = 20;
    pause = 1;
    for (int i = 0; i < 4; i++) push_write(DW'(8'hD0 + i));
    s0 = starts;
    pause = 0;
    n = 0;
    while (starts == s0 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_test_started", starts - s0, 1);
    pause = 1;
    tick();
    tick();
    chk("wait_idle_count", count, 3);
    rst = 1;
    tick();
    check_reset("mid_reset");
    rst = 0;
    exp_q.delete();
    pause = 0;
    repeat (30) tick();
    chk("no_start_after_rst", starts - s0, 1);
    chk("after_rst_empty", empty, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
